// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for bus_arbiter: FSM state encoding, grant-side
// identifiers and bus handshake constants.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_e;

    // Byte write enables that mean "read"; also used for every fetch.
    localparam logic [3:0] WEN_READ = 4'b0000;

    // Last-grant encoding used by the round-robin option.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter -- arbitrates an instruction-fetch port and a data port onto a
// single SRAM-like bus with separate address and data handshakes. One
// transaction is outstanding at a time, and new grants are made only from IDLE.
//
// Build option: BUS_ARB_RR_EN. When defined, simultaneous requests in IDLE are
// granted round-robin using a last-grant register. When undefined, the data
// side has fixed priority.
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   i_en, i_addr, i_flush                fetch request, address, discard
//   i_rdata, i_streq                     fetch data, IF stall request
//   d_en, d_wen, d_addr, d_wdata         data request (wen 0000 = read)
//   d_rdata, d_streq                     load data, MEM stall request
//   bus_req, bus_wen, bus_addr, bus_wdata  bus request
//   bus_addr_ok, bus_data_ok, bus_rdata    bus handshakes and read data
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic [DW-1:0] i_rdata,
    output logic          i_streq,
    input  logic          d_en,
    input  logic [3:0]    d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_streq,
    output logic          bus_req,
    output logic [3:0]    bus_wen,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata
);

    arb_state_e    state_q, state_d;
    logic          discard_q;
    logic [3:0]    wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] i_rdata_q, d_rdata_q;

    logic i_pend, grant_i, grant_d;
    logic i_discard, i_done, d_done;

    // A flushed fetch is not a request worth starting.
    assign i_pend = i_en && !i_flush;

`ifdef BUS_ARB_RR_EN
    logic last_q;

    // When both sides are pending, the side that was not served last wins.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (d_en && (!i_pend || last_q == GRANT_I))
            grant_d = 1'b1;
        else if (i_pend)
            grant_i = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_q <= GRANT_I;
        else if (state_q == IDLE && (grant_d || grant_i))
            last_q <= grant_d ? GRANT_D : GRANT_I;
    end
`else
    always_comb begin
        grant_d = d_en;
        grant_i = i_pend && !d_en;
    end
`endif

    // A flush arriving in the same cycle as data_ok must already suppress
    // the completion, so the live input is ORed with the sticky flag.
    assign i_discard = discard_q || i_flush;
    assign i_done    = (state_q == I_DATA) && bus_data_ok && !i_discard;
    assign d_done    = (state_q == D_DATA) && bus_data_ok;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)
                    state_d = D_ADDR;
                else if (grant_i)
                    state_d = I_ADDR;
            end
            I_ADDR: if (bus_addr_ok) state_d = I_DATA;
            D_ADDR: if (bus_addr_ok) state_d = D_DATA;
            I_DATA: if (bus_data_ok) state_d = IDLE;
            D_DATA: if (bus_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, discard flag and read-data latches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wen_q     <= WEN_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            discard_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            // Capture at grant so the bus stays stable while the requester
            // changes its inputs during a stalled address phase.
            if (state_q == IDLE) begin
                if (grant_d) begin
                    wen_q   <= d_wen;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                end else if (grant_i) begin
                    wen_q   <= WEN_READ;
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                end
            end

            // The flush never aborts the bus handshake; it only marks the
            // fetch as unwanted until the FSM is back in IDLE.
            if (state_d == IDLE)
                discard_q <= 1'b0;
            else if (i_flush && (state_q == I_ADDR || state_q == I_DATA))
                discard_q <= 1'b1;

            if (i_done) i_rdata_q <= bus_rdata;
            if (d_done) d_rdata_q <= bus_rdata;
        end
    end

    assign bus_req   = (state_q == I_ADDR) || (state_q == D_ADDR);
    assign bus_wen   = wen_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign i_rdata = i_done ? bus_rdata : i_rdata_q;
    assign d_rdata = d_done ? bus_rdata : d_rdata_q;
    assign i_streq = i_en && !i_done;
    assign d_streq = d_en && !d_done;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. A bus slave model with programmable
// address/data delays answers the arbiter. Expected bus transactions and
// completions are queued by the stimulus and checked by a monitor.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_en, i_flush;
    logic [31:0] i_addr, i_rdata;
    logic        i_streq;
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_streq;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_en(i_en), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_streq(i_streq),
        .d_en(d_en), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_streq(d_streq),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- bus slave model ----------------
    int          addr_wait = 0;
    int          data_wait = 0;
    int          a_cnt = 0;
    int          d_cnt = 0;
    logic        pending = 1'b0;
    logic [31:0] slave_rdata = 32'h0;

    assign bus_addr_ok = bus_req && !pending && (a_cnt >= addr_wait);
    assign bus_data_ok = pending && (d_cnt >= data_wait);
    assign bus_rdata   = slave_rdata;

    always @(posedge clk) begin
        if (bus_req && !bus_addr_ok) a_cnt <= a_cnt + 1;
        else                         a_cnt <= 0;
        if (bus_req && bus_addr_ok) begin
            pending <= 1'b1;
            d_cnt   <= 0;
        end else if (bus_data_ok) begin
            pending <= 1'b0;
        end else if (pending) begin
            d_cnt <= d_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } cpl_t;

    bus_t exp_bus[$];
    cpl_t exp_i[$];
    cpl_t exp_d[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", name);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus_req && bus_addr_ok) begin
                if (exp_bus.size() == 0) unexpected("bus_unexpected");
                else begin
                    bus_t e;
                    e = exp_bus.pop_front();
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_wen", {28'h0, bus_wen}, {28'h0, e.wen});
                    if (e.wen != 4'b0000) check("bus_wdata", bus_wdata, e.wdata);
                end
            end
            if (i_en && !i_streq) begin
                if (exp_i.size() == 0) unexpected("i_cpl_unexpected");
                else begin
                    cpl_t c;
                    c = exp_i.pop_front();
                    if (c.chk) check("i_rdata_cpl", i_rdata, c.data);
                end
            end
            if (d_en && !d_streq) begin
                if (exp_d.size() == 0) unexpected("d_cpl_unexpected");
                else begin
                    cpl_t c;
                    c = exp_d.pop_front();
                    if (c.chk) check("d_rdata_cpl", d_rdata, c.data);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a side's completion cycle; returns at its negedge.
    task automatic wait_done(input bit side_d, input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (side_d ? !d_streq : !i_streq) return;
        end
        unexpected({name, "_timeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] last_i;
    int          n;

    initial begin
        resetn = 1'b0;
        i_en = 0; i_flush = 0; i_addr = '0;
        d_en = 0; d_wen = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        resetn = 1'b1;
        step();
        check("rst_i_streq", {31'h0, i_streq}, 32'h0);
        check("rst_d_streq", {31'h0, d_streq}, 32'h0);

        // Single fetch, immediate handshakes: 2 stall cycles then done.
        slave_rdata = 32'h3C080001;
        exp_bus.push_back('{32'hBFC00000, 4'b0000, 32'h0});
        exp_i.push_back('{1'b1, 32'h3C080001});
        i_en = 1; i_addr = 32'hBFC00000;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!i_streq) break;
            n++;
        end
        check("fetch_stall_cycles", n, 2);
        check("fetch_rdata", i_rdata, 32'h3C080001);
        step();
        i_en = 0; slave_rdata = 32'h0;
        @(negedge clk);
        check("fetch_rdata_held", i_rdata, 32'h3C080001);
        last_i = 32'h3C080001;

        // Simultaneous requests: data write first, then fetch.
        step();
        slave_rdata = 32'h24020005;
        exp_bus.push_back('{32'h80000010, 4'b1111, 32'hDEADBEEF});
        exp_bus.push_back('{32'hBFC00004, 4'b0000, 32'h0});
        exp_d.push_back('{1'b0, 32'h0});
        exp_i.push_back('{1'b1, 32'h24020005});
        i_en = 1; i_addr = 32'hBFC00004;
        d_en = 1; d_wen = 4'b1111; d_addr = 32'h80000010; d_wdata = 32'hDEADBEEF;
        wait_done(1'b1, "both_d");
        check("both_i_stalled", {31'h0, i_streq}, 32'h1);
        step();
        d_en = 0; d_wen = 4'b0000;
        wait_done(1'b0, "both_i");
        step();
        i_en = 0;
        last_i = 32'h24020005;

        // Flush during the address phase: bus_req held, result discarded.
        step();
        addr_wait = 2; slave_rdata = 32'h55AA55AA;
        exp_bus.push_back('{32'hBFC0000C, 4'b0000, 32'h0});
        i_en = 1; i_addr = 32'hBFC0000C;
        step();
        step();
        i_flush = 1;
        @(negedge clk);
        check("flush_addr_req", {31'h0, bus_req}, 32'h1);
        step();
        i_flush = 0;
        @(negedge clk);
        check("flush_addr_req_hold", {31'h0, bus_req}, 32'h1);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("flush_addr_streq", {31'h0, i_streq}, 32'h1);
            if (bus_data_ok) break;
        end
        check("flush_addr_rdata", i_rdata, last_i);
        step();
        i_en = 0; addr_wait = 0;

        // Flush during the data phase, data_ok four cycles later.
        step();
        data_wait = 4; slave_rdata = 32'hCAFEF00D;
        exp_bus.push_back('{32'hBFC00008, 4'b0000, 32'h0});
        i_en = 1; i_addr = 32'hBFC00008;
        step();
        step();
        i_flush = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("flush_data_streq", {31'h0, i_streq}, 32'h1);
            check("flush_data_rdata", i_rdata, last_i);
            if (bus_data_ok) break;
        end
        repeat (2) begin
            @(negedge clk);
            check("flush_data_idle", {31'h0, bus_req}, 32'h0);
        end
        step();
        i_en = 0; i_flush = 0; data_wait = 0;

        // Address phase stalled 5 cycles while d_addr/d_wdata wander.
        step();
        addr_wait = 5;
        exp_bus.push_back('{32'h80000040, 4'b0011, 32'h12345678});
        exp_d.push_back('{1'b0, 32'h0});
        d_en = 1; d_wen = 4'b0011; d_addr = 32'h80000040; d_wdata = 32'h12345678;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_bus_req", {31'h0, bus_req}, 32'h1);
            check("stall_bus_addr", bus_addr, 32'h80000040);
            check("stall_bus_wdata", bus_wdata, 32'h12345678);
            step();
            d_addr = 32'h90000000 + k; d_wdata = ~d_wdata;
        end
        wait_done(1'b1, "stall_d");
        step();
        d_en = 0; d_wen = 4'b0000; addr_wait = 0;

        // Reset during D_DATA: transaction abandoned, late data_ok ignored.
        step();
        data_wait = 6; slave_rdata = 32'h77777777;
        exp_bus.push_back('{32'h80000020, 4'b0000, 32'h0});
        d_en = 1; d_addr = 32'h80000020;
        step();
        step();
        step();
        resetn = 0;
        #1;
        check("rst_mid_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_mid_d_rdata", d_rdata, 32'h0);
        check("rst_mid_i_rdata", i_rdata, 32'h0);
        d_en = 0;
        step();
        resetn = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("rst_late_d_rdata", d_rdata, 32'h0);
            check("rst_late_bus_req", {31'h0, bus_req}, 32'h0);
            if (!pending) break;
        end
        data_wait = 0;

        // Both sides pending continuously for four grants.
        step();
        slave_rdata = 32'h11112222;
`ifdef BUS_ARB_RR_EN
        for (int k = 0; k < 2; k++) begin
            exp_bus.push_back('{32'h80000100, 4'b0000, 32'h0});
            exp_bus.push_back('{32'hBFC00100, 4'b0000, 32'h0});
            exp_d.push_back('{1'b1, 32'h11112222});
            exp_i.push_back('{1'b1, 32'h11112222});
        end
`else
        for (int k = 0; k < 4; k++) begin
            exp_bus.push_back('{32'h80000100, 4'b0000, 32'h0});
            exp_d.push_back('{1'b1, 32'h11112222});
        end
`endif
        i_en = 1; i_addr = 32'hBFC00100;
        d_en = 1; d_wen = 4'b0000; d_addr = 32'h80000100;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_req && bus_addr_ok) n++;
            if (n == 4) break;
        end
        check("pair_grants", n, 4);
        step();
        step();
        i_en = 0; d_en = 0;
        repeat (3) step();

        check("exp_bus_drained", exp_bus.size(), 0);
        check("exp_i_drained", exp_i.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_en in 1, i_addr in AW, i_flush in 1  instruction-side fetch request, address and discard.
REQ-006 SHALL have ports i_rdata out DW, i_streq out 1  fetch data and IF stall request.
REQ-007 SHALL have ports d_en in 1, d_wen in 4, d_addr in AW, d_wdata in DW  data-side request, byte write enables (0000 = read), address and write data.
REQ-008 SHALL have ports d_rdata out DW, d_streq out 1  load data and MEM stall request.
REQ-009 SHALL have ports bus_req out 1, bus_wen out 4, bus_addr out AW, bus_wdata out DW  shared SRAM-like bus request.
REQ-010 SHALL have ports bus_addr_ok in 1, bus_data_ok in 1, bus_rdata in DW  bus address and data handshakes.

Function
REQ-011 SHALL implement FSM states IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
REQ-012 IDLE: d_en -> D_ADDR; else i_en && !i_flush -> I_ADDR; else stay IDLE; no bus activity in IDLE.
REQ-013 X_ADDR: bus_req=1, bus_addr/wen/wdata from granted side; on bus_addr_ok -> X_DATA, bus_req=0 from next cycle.
REQ-014 X_DATA: bus_req=0; on bus_data_ok -> IDLE.
REQ-015 bus_wen SHALL be 0000 for instruction grants.
REQ-016 i_streq = i_en && !(state==I_DATA && bus_data_ok && !discard); d_streq likewise for d_en/D_DATA; both combinational.
REQ-017 On the completion cycle rdata SHALL pass bus_rdata combinationally and latch it; latched value held until next completion of that side.
REQ-018 Minimum latency request-to-completion SHALL be 3 cycles (IDLE, ADDR with addr_ok, DATA with data_ok).
REQ-019 i_flush in I_ADDR SHALL NOT withdraw bus_req; handshake completes, a discard flag is set, transaction proceeds.
REQ-020 i_flush in I_DATA, or same cycle as bus_data_ok, SHALL set/apply discard: i_rdata not updated, no completion signalled.
REQ-021 Discard flag SHALL clear on return to IDLE; i_flush has no effect on data-side transactions.
REQ-022 A granted side's request inputs SHALL be captured at grant and held on the bus independent of later input changes.
REQ-023 At most one transaction outstanding; new grants only from IDLE.

Reset
REQ-024 resetn low SHALL asynchronously force IDLE, bus_req=0, discard=0, i_rdata=0, d_rdata=0, last-grant=instruction.
REQ-025 Reset mid-transaction SHALL abandon it; no completion reported after release.

Configuration
REQ-026 BUS_ARB_RR_EN defined: when i_en and d_en both pending in IDLE, grant the side not granted last (round-robin via last-grant register).
REQ-027 BUS_ARB_RR_EN undefined: fixed data-side priority per REQ-012; last-grant register absent.

Structure
REQ-028 FSM state encodings and handshake constants SHALL live in the shared defines header.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 i_en=1, i_addr=0xBFC00000, addr_ok/data_ok immediate, bus_rdata=0x3C080001 -> i_streq high 2 cycles, low 3rd, i_rdata=0x3C080001.
REQ-031 i_en and d_en (d_wen=1111, d_addr=0x80000010, d_wdata=0xDEADBEEF) same cycle, no RR -> data write issued first, fetch after.
REQ-032 With BUS_ARB_RR_EN, both pending repeatedly -> grants alternate D,I,D,I.
REQ-033 i_flush in I_DATA with data_ok 4 cycles later -> i_rdata unchanged, i_streq stays set while i_en=1, FSM IDLE afterwards.
REQ-034 resetn low during D_DATA -> bus_req=0, state IDLE immediately; later data_ok ignored.
REQ-035 addr_ok held low 5 cycles in D_ADDR -> bus_req and bus_addr stable all 5 cycles despite d_addr changes.
